// File: rtl/uart_tx_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// uart_tx_arbiter_pkg : state encoding, requester indices, baud divider helper
// Rev 1.0
// ============================================================================
package uart_tx_arbiter_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  localparam logic REQ_DBG = 1'b0;
  localparam logic REQ_APP = 1'b1;

  function automatic int calc_div(input int clk_freq, input int baudrate);
    return clk_freq / baudrate;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_serializer.sv
`default_nettype none
// ============================================================================
// uart_tx_serializer : 8N1 LSB-first frame generator with registered line
// Rev 1.0
// ============================================================================
module uart_tx_serializer
  import uart_tx_arbiter_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic [7:0] data_i,
  output logic       txd_o,
  output logic       busy_o,
  output logic       idle_o
);

  localparam int BW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(DIV - 1);

  logic [1:0]    state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          txd_q, txd_d;
  logic          baud_end;

  assign baud_end = (baud_q == BAUD_LAST);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    txd_d   = txd_q;
    case (state_q)
      ST_IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        txd_d  = 1'b1;
        if (start_i) begin
          state_d = ST_START;
          shift_d = data_i;
          txd_d   = 1'b0;
        end
      end
      ST_START: begin
        if (baud_end) begin
          baud_d  = '0;
          state_d = ST_DATA;
          txd_d   = shift_q[0];
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      ST_DATA: begin
        // The line register is loaded one bit ahead so txd_o changes exactly on the bit boundary.
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = ST_STOP;
            bit_d   = '0;
            txd_d   = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            txd_d   = shift_q[1];
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: begin
        txd_d = 1'b1;
        if (baud_end) begin
          baud_d  = '0;
          state_d = ST_IDLE;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
    end
  end

  assign txd_o  = txd_q;
  assign idle_o = (state_q == ST_IDLE);
  assign busy_o = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// uart_tx_arbiter : two-requester packet-locking round-robin UART transmitter
// Rev 1.0
// ============================================================================
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int CLK_FREQ     = 32000000,
  parameter int BAUDRATE     = 115200,
  parameter int LOCK_TIMEOUT = 65535
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       dbg_valid_i,
  input  logic [7:0] dbg_data_i,
  input  logic       dbg_last_i,
  output logic       dbg_accept_o,
  input  logic       app_valid_i,
  input  logic [7:0] app_data_i,
  input  logic       app_last_i,
  output logic       app_accept_o,
  output logic       txd_o,
  output logic       busy_o,
  output logic [1:0] grant_o
);

  localparam int DIV = calc_div(CLK_FREQ, BAUDRATE);
  localparam int TW  = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(LOCK_TIMEOUT - 1);

  logic          ser_idle;
  logic          ser_busy;
  logic          sel;
  logic          sel_valid;
  logic          sel_last;
  logic [7:0]    sel_data;
  logic          start;

  logic          lock_q, lock_d;
  logic          owner_q, owner_d;
  logic          prio_q, prio_d;
  logic [TW-1:0] tmo_q, tmo_d;

  // While locked only the owner is eligible; otherwise prio_q breaks ties.
  always_comb begin
    sel       = prio_q;
    sel_valid = 1'b0;
    if (lock_q) begin
      sel       = owner_q;
      sel_valid = (owner_q == REQ_APP) ? app_valid_i : dbg_valid_i;
    end else if (dbg_valid_i && app_valid_i) begin
      sel       = prio_q;
      sel_valid = 1'b1;
    end else if (dbg_valid_i) begin
      sel       = REQ_DBG;
      sel_valid = 1'b1;
    end else if (app_valid_i) begin
      sel       = REQ_APP;
      sel_valid = 1'b1;
    end
  end

  assign sel_last = (sel == REQ_APP) ? app_last_i : dbg_last_i;
  assign sel_data = (sel == REQ_APP) ? app_data_i : dbg_data_i;
  assign start    = ser_idle && sel_valid;

  always_comb begin
    lock_d  = lock_q;
    owner_d = owner_q;
    prio_d  = prio_q;
    tmo_d   = '0;
    if (start) begin
      if (sel_last) begin
        lock_d = 1'b0;
        prio_d = ~sel;
      end else begin
        lock_d  = 1'b1;
        owner_d = sel;
      end
    end else if (lock_q && ser_idle) begin
      // Owner is stalled here; drop the lock once the idle budget is spent.
      if (tmo_q == TMO_LAST) begin
        lock_d = 1'b0;
        prio_d = ~owner_q;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_q  <= 1'b0;
      owner_q <= REQ_DBG;
      prio_q  <= REQ_DBG;
      tmo_q   <= '0;
    end else begin
      lock_q  <= lock_d;
      owner_q <= owner_d;
      prio_q  <= prio_d;
      tmo_q   <= tmo_d;
    end
  end

  uart_tx_serializer #(
    .DIV (DIV)
  ) u_serializer (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .start_i (start),
    .data_i  (sel_data),
    .txd_o   (txd_o),
    .busy_o  (ser_busy),
    .idle_o  (ser_idle)
  );

  assign dbg_accept_o = start && (sel == REQ_DBG);
  assign app_accept_o = start && (sel == REQ_APP);
  assign busy_o       = ser_busy;
  assign grant_o      = lock_q ? ((owner_q == REQ_APP) ? 2'b10 : 2'b01) : 2'b00;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// tb_uart_tx_arbiter : self-checking bench with a transaction-level reference
// Rev 1.0
// ============================================================================
module tb_uart_tx_arbiter;

  localparam int DIV   = 4;
  localparam int LT    = 16;
  localparam int FRAME = 10 * DIV;

  logic       clk;
  logic       rst_n;
  logic       dbg_valid, dbg_last, dbg_accept;
  logic [7:0] dbg_data;
  logic       app_valid, app_last, app_accept;
  logic [7:0] app_data;
  logic       txd, busy;
  logic [1:0] grant;

  logic       s_txd, s_busy, s_dacc, s_aacc;
  logic [1:0] s_grant;
  int         checks;
  int         errors;

  uart_tx_arbiter #(
    .CLK_FREQ     (8),
    .BAUDRATE     (2),
    .LOCK_TIMEOUT (LT)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .dbg_valid_i  (dbg_valid),
    .dbg_data_i   (dbg_data),
    .dbg_last_i   (dbg_last),
    .dbg_accept_o (dbg_accept),
    .app_valid_i  (app_valid),
    .app_data_i   (app_data),
    .app_last_i   (app_last),
    .app_accept_o (app_accept),
    .txd_o        (txd),
    .busy_o       (busy),
    .grant_o      (grant)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Line level of an 8N1 frame at bit slot idx (0 = start, 1..8 = data LSB first, 9 = stop).
  function automatic logic frame_bit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx >= 9) return 1'b1;
    return b[idx-1];
  endfunction

  task automatic tick();
    @(negedge clk);
    s_txd   = txd;
    s_busy  = busy;
    s_grant = grant;
    s_dacc  = dbg_accept;
    s_aacc  = app_accept;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    dbg_valid = 1'b0; dbg_data = 8'h00; dbg_last = 1'b0;
    app_valid = 1'b0; app_data = 8'h00; app_last = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    checks++; if (s_txd !== 1'b1) begin errors++; $display("FAIL reset_txd got=%b exp=1", s_txd); end
    checks++; if (s_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", s_busy); end
    checks++; if (s_grant !== 2'b00) begin errors++; $display("FAIL reset_grant got=%b exp=00", s_grant); end
    checks++; if ({s_dacc, s_aacc} !== 2'b00) begin errors++; $display("FAIL reset_accept got=%b exp=00", {s_dacc, s_aacc}); end
    rst_n = 1'b1;
    tick();
    checks++; if ({s_txd, s_busy, s_grant} !== 4'b1000) begin errors++; $display("FAIL reset_release got=%b exp=1000", {s_txd, s_busy, s_grant}); end
  endtask

  task automatic test_single_frame(input logic [7:0] b);
    int busy_cnt;
    busy_cnt = 0;
    dbg_valid = 1'b1; dbg_data = b; dbg_last = 1'b1;
    tick();
    checks++; if ({s_dacc, s_aacc, s_busy} !== 3'b100) begin errors++; $display("FAIL frame_accept byte=%h got=%b exp=100", b, {s_dacc, s_aacc, s_busy}); end
    dbg_valid = 1'b0; dbg_data = ~b;
    for (int k = 1; k <= FRAME; k++) begin
      tick();
      if (s_busy === 1'b1) busy_cnt++;
      checks++;
      if (s_txd !== frame_bit(b, (k - 1) / DIV)) begin
        errors++; $display("FAIL frame_txd byte=%h cycle=%0d got=%b exp=%b", b, k, s_txd, frame_bit(b, (k - 1) / DIV));
      end
    end
    checks++; if (busy_cnt != FRAME) begin errors++; $display("FAIL frame_busy_len got=%0d exp=%0d", busy_cnt, FRAME); end
    tick();
    checks++; if ({s_txd, s_busy} !== 2'b10) begin errors++; $display("FAIL frame_end got=%b exp=10", {s_txd, s_busy}); end
  endtask

  task automatic test_round_robin();
    int  n, prev;
    logic exp_app;
    do_reset();
    dbg_valid = 1'b1; dbg_data = 8'h11; dbg_last = 1'b1;
    app_valid = 1'b1; app_data = 8'h22; app_last = 1'b1;
    n = 0; prev = -1; exp_app = 1'b0;
    for (int t = 0; t < 6 * (FRAME + 1) && n < 4; t++) begin
      tick();
      checks++; if (s_dacc && s_aacc) begin errors++; $display("FAIL rr_both got=11 exp=not both"); end
      if (s_dacc || s_aacc) begin
        checks++;
        if (s_aacc !== exp_app) begin errors++; $display("FAIL rr_order n=%0d got_app=%b exp_app=%b", n, s_aacc, exp_app); end
        checks++;
        if (prev < 0 && t != 0) begin errors++; $display("FAIL rr_first got=%0d exp=0", t); end
        else if (prev >= 0 && t - prev != FRAME + 1) begin errors++; $display("FAIL rr_spacing got=%0d exp=%0d", t - prev, FRAME + 1); end
        prev = t; exp_app = !exp_app; n++;
      end
    end
    checks++; if (n != 4) begin errors++; $display("FAIL rr_timeout got=%0d exp=4", n); end
    idle_inputs();
  endtask

  task automatic test_lock();
    logic [8:0] pk [3];
    int   idx, napp;
    logic locked;
    pk[0] = 9'h001; pk[1] = 9'h002; pk[2] = 9'h103;
    do_reset();
    app_valid = 1'b1; app_data = 8'h22; app_last = 1'b1;
    idx = 0; napp = 0; locked = 1'b0;
    for (int t = 0; t < 8 * (FRAME + 1) && napp == 0; t++) begin
      if (idx < 3) begin dbg_valid = 1'b1; dbg_data = pk[idx][7:0]; dbg_last = pk[idx][8]; end
      else dbg_valid = 1'b0;
      tick();
      checks++;
      if (s_grant !== (locked ? 2'b01 : 2'b00)) begin errors++; $display("FAIL lock_grant t=%0d got=%b exp=%b", t, s_grant, locked ? 2'b01 : 2'b00); end
      if (s_dacc) begin
        checks++;
        if (idx >= 3) begin errors++; $display("FAIL lock_extra_dbg got=%0d exp=3", idx + 1); end
        else begin locked = !pk[idx][8]; idx++; end
      end
      if (s_aacc) begin
        checks++;
        if (idx != 3) begin errors++; $display("FAIL lock_app_early got=%0d exp=3", idx); end
        napp++;
      end
    end
    checks++; if (napp == 0) begin errors++; $display("FAIL lock_timeout got=0 exp=1"); end
    idle_inputs();
  endtask

  task automatic test_timeout();
    int exp_t, got_t;
    do_reset();
    dbg_valid = 1'b1; dbg_data = 8'h01; dbg_last = 1'b0;
    app_valid = 1'b1; app_data = 8'h33; app_last = 1'b1;
    tick();
    checks++; if ({s_dacc, s_aacc} !== 2'b10) begin errors++; $display("FAIL to_first got=%b exp=10", {s_dacc, s_aacc}); end
    dbg_valid = 1'b0;
    exp_t = FRAME + LT + 1;
    got_t = -1;
    for (int t = 1; t <= exp_t + 20 && got_t < 0; t++) begin
      tick();
      checks++;
      if (s_grant !== ((t < exp_t) ? 2'b01 : 2'b00)) begin errors++; $display("FAIL to_grant t=%0d got=%b exp=%b", t, s_grant, (t < exp_t) ? 2'b01 : 2'b00); end
      checks++; if (s_dacc) begin errors++; $display("FAIL to_dbg_accept t=%0d got=1 exp=0", t); end
      if (s_aacc) got_t = t;
    end
    checks++; if (got_t != exp_t) begin errors++; $display("FAIL to_app_accept got=%0d exp=%0d", got_t, exp_t); end
    idle_inputs();
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] b, c;
    b = 8'($urandom) & 8'hF7;
    c = 8'($urandom);
    do_reset();
    dbg_valid = 1'b1; dbg_data = b; dbg_last = 1'b0;
    tick();
    checks++; if (s_dacc !== 1'b1) begin errors++; $display("FAIL mrst_accept got=%b exp=1", s_dacc); end
    dbg_valid = 1'b0;
    for (int k = 1; k <= 1 + 4 * DIV; k++) tick();
    checks++; if (s_txd !== frame_bit(b, 4)) begin errors++; $display("FAIL mrst_bit3 got=%b exp=%b", s_txd, frame_bit(b, 4)); end
    rst_n = 1'b0;
    tick();
    checks++; if ({s_txd, s_busy, s_grant} !== 4'b1000) begin errors++; $display("FAIL mrst_forced got=%b exp=1000", {s_txd, s_busy, s_grant}); end
    tick();
    rst_n = 1'b1;
    tick();
    checks++; if ({s_txd, s_busy, s_grant} !== 4'b1000) begin errors++; $display("FAIL mrst_no_resume got=%b exp=1000", {s_txd, s_busy, s_grant}); end
    app_valid = 1'b1; app_data = c; app_last = 1'b1;
    tick();
    checks++; if ({s_dacc, s_aacc, s_grant} !== 4'b0100) begin errors++; $display("FAIL mrst_new_accept got=%b exp=0100", {s_dacc, s_aacc, s_grant}); end
    app_valid = 1'b0;
    for (int k = 1; k <= FRAME; k++) begin
      tick();
      checks++;
      if (s_txd !== frame_bit(c, (k - 1) / DIV)) begin errors++; $display("FAIL mrst_frame cycle=%0d got=%b exp=%b", k, s_txd, frame_bit(c, (k - 1) / DIV)); end
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_data_change();
    logic [7:0] b;
    b = 8'($urandom);
    do_reset();
    app_valid = 1'b1; app_data = b; app_last = 1'b1;
    tick();
    checks++; if ({s_dacc, s_aacc} !== 2'b01) begin errors++; $display("FAIL dc_accept got=%b exp=01", {s_dacc, s_aacc}); end
    for (int k = 1; k <= FRAME; k++) begin
      dbg_valid = 1'($urandom); dbg_data = 8'($urandom); dbg_last = 1'($urandom);
      app_valid = 1'($urandom); app_data = 8'($urandom); app_last = 1'($urandom);
      tick();
      checks++;
      if (s_txd !== frame_bit(b, (k - 1) / DIV)) begin errors++; $display("FAIL dc_txd cycle=%0d got=%b exp=%b", k, s_txd, frame_bit(b, (k - 1) / DIV)); end
      checks++; if (s_dacc || s_aacc) begin errors++; $display("FAIL dc_busy_accept cycle=%0d got=%b exp=00", k, {s_dacc, s_aacc}); end
    end
    idle_inputs();
    tick();
    checks++; if ({s_txd, s_busy} !== 2'b10) begin errors++; $display("FAIL dc_end got=%b exp=10", {s_txd, s_busy}); end
  endtask

  task automatic test_random_packets();
    logic [8:0] dq[$];
    logic [8:0] aq[$];
    int         dlen[$];
    int         alen[$];
    logic       exp_req[$];
    logic [7:0] exp_byte[$];
    logic       exp_last[$];
    int         di, ai, dp, ap, ei, t, last_acc, budget, len, rel;
    logic       pr, who, locked, owner, in_frame, got;
    logic [7:0] cur_byte;
    logic [1:0] exp_grant;
    do_reset();
    for (int p = 0; p < 5; p++) begin
      len = $urandom_range(1, 3); dlen.push_back(len);
      for (int j = 0; j < len; j++) dq.push_back({(j == len - 1), 8'($urandom)});
      len = $urandom_range(1, 3); alen.push_back(len);
      for (int j = 0; j < len; j++) aq.push_back({(j == len - 1), 8'($urandom)});
    end
    // Reference: whole packets served alternately, dbg first, leftovers in order.
    di = 0; ai = 0; dp = 0; ap = 0; pr = 1'b0;
    while (dp < dlen.size() || ap < alen.size()) begin
      if (dp < dlen.size() && ap < alen.size()) who = pr;
      else who = (ap < alen.size());
      if (!who) begin
        for (int j = 0; j < dlen[dp]; j++) begin
          exp_req.push_back(1'b0); exp_byte.push_back(dq[di][7:0]); exp_last.push_back(dq[di][8]); di++;
        end
        dp++;
      end else begin
        for (int j = 0; j < alen[ap]; j++) begin
          exp_req.push_back(1'b1); exp_byte.push_back(aq[ai][7:0]); exp_last.push_back(aq[ai][8]); ai++;
        end
        ap++;
      end
      pr = !who;
    end
    ei = 0; t = 0; last_acc = -1; locked = 1'b0; owner = 1'b0; cur_byte = 8'h00;
    budget = (exp_req.size() + 2) * (FRAME + 1);
    while (t < budget && (ei < exp_req.size() || (last_acc >= 0 && t <= last_acc + FRAME + 1))) begin
      rel = t - last_acc;
      in_frame = (last_acc >= 0) && (rel >= 1) && (rel <= FRAME);
      if (in_frame) begin
        dbg_valid = 1'($urandom); dbg_data = 8'($urandom); dbg_last = 1'($urandom);
        app_valid = 1'($urandom); app_data = 8'($urandom); app_last = 1'($urandom);
      end else begin
        if (dq.size() > 0) begin dbg_valid = 1'b1; dbg_data = dq[0][7:0]; dbg_last = dq[0][8]; end
        else begin dbg_valid = 1'b0; dbg_data = 8'($urandom); dbg_last = 1'b0; end
        if (aq.size() > 0) begin app_valid = 1'b1; app_data = aq[0][7:0]; app_last = aq[0][8]; end
        else begin app_valid = 1'b0; app_data = 8'($urandom); app_last = 1'b0; end
      end
      tick();
      exp_grant = locked ? (owner ? 2'b10 : 2'b01) : 2'b00;
      checks++; if (s_grant !== exp_grant) begin errors++; $display("FAIL rand_grant t=%0d got=%b exp=%b", t, s_grant, exp_grant); end
      checks++; if (s_dacc && s_aacc) begin errors++; $display("FAIL rand_both t=%0d got=11 exp=not both", t); end
      got = s_dacc || s_aacc;
      checks++;
      if (in_frame) begin
        if (s_txd !== frame_bit(cur_byte, (rel - 1) / DIV) || s_busy !== 1'b1 || got) begin
          errors++; $display("FAIL rand_frame t=%0d got txd/busy/acc=%b%b%b exp=%b10", t, s_txd, s_busy, got, frame_bit(cur_byte, (rel - 1) / DIV));
        end
      end else if (s_txd !== 1'b1 || s_busy !== 1'b0) begin
        errors++; $display("FAIL rand_idle t=%0d got txd/busy=%b%b exp=10", t, s_txd, s_busy);
      end
      if (!in_frame && ei < exp_req.size()) begin
        checks++; if (!got) begin errors++; $display("FAIL rand_stall t=%0d got=no accept exp=accept %0d", t, ei); end
      end
      if (!in_frame && got) begin
        if (ei >= exp_req.size()) begin
          checks++; errors++; $display("FAIL rand_extra t=%0d got=accept exp=none", t);
        end else begin
          checks++;
          if (s_aacc !== exp_req[ei]) begin errors++; $display("FAIL rand_order idx=%0d got_app=%b exp_app=%b", ei, s_aacc, exp_req[ei]); end
          if (last_acc >= 0) begin
            checks++; if (t - last_acc != FRAME + 1) begin errors++; $display("FAIL rand_spacing got=%0d exp=%0d", t - last_acc, FRAME + 1); end
          end
          cur_byte = exp_byte[ei];
          if (exp_last[ei]) locked = 1'b0;
          else begin locked = 1'b1; owner = exp_req[ei]; end
          ei++;
        end
        last_acc = t;
        if (s_aacc) begin if (aq.size() > 0) void'(aq.pop_front()); end
        else if (dq.size() > 0) void'(dq.pop_front());
      end
      t++;
    end
    checks++; if (ei != exp_req.size()) begin errors++; $display("FAIL rand_timeout got=%0d exp=%0d", ei, exp_req.size()); end
    idle_inputs();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    idle_inputs();
    @(posedge clk);
    #1;
    test_reset();
    test_single_frame(8'hA5);
    test_single_frame(8'($urandom));
    test_single_frame(8'($urandom));
    test_round_robin();
    test_lock();
    test_timeout();
    test_reset_mid_frame();
    test_data_change();
    test_random_packets();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter CLK_FREQ, default 32000000, is the clock frequency in Hz.
REQ-002 Parameter BAUDRATE, default 115200, is the line rate; DIV = CLK_FREQ/BAUDRATE (integer, truncated) clocks per bit; DIV >= 2.
REQ-003 Parameter LOCK_TIMEOUT, default 65535, is the number of idle cycles before a stalled packet lock is dropped.
REQ-004 One clock, clk_i (input, 1), rising-edge; reset rst_ni (input, 1), asynchronous, active-low.
REQ-005 dbg_valid_i (input, 1): requester 0 has a byte; dbg_data_i (input, 8): the byte; dbg_last_i (input, 1): last byte of packet; dbg_accept_o (output, 1): byte taken this cycle.
REQ-006 app_valid_i, app_data_i, app_last_i, app_accept_o: same as REQ-005, for requester 1.
REQ-007 txd_o (output, 1): serial line, registered, idle high.
REQ-008 busy_o (output, 1) is high when state is not IDLE; grant_o (output, 2) is one-hot lock owner, 2'b00 when unlocked.

Function
REQ-009 The serializer states are IDLE, START, DATA, STOP; the frame is 8N1, LSB first.
REQ-010 In IDLE, the arbiter selects one requester; a byte is accepted (accept_o high for exactly that one cycle, data captured) only in IDLE.
REQ-011 Accept in cycle N: txd_o is low from cycle N+1 for DIV cycles (START), then bits 0..7 for DIV cycles each (DATA), then high for DIV cycles (STOP), then IDLE.
REQ-012 Back-to-back frames repeat every 10*DIV+1 cycles, because each frame includes one IDLE cycle.
REQ-013 While unlocked, when both requesters are valid, the winner is the requester not served by the most recently completed packet; after reset, dbg wins.
REQ-014 Accepting a byte with last_i=0 locks the grant to that requester; only the locked requester can be accepted until its byte with last_i=1 is accepted.
REQ-015 Accepting a byte with last_i=1 clears the lock and flips round-robin priority; a single-byte packet never locks.
REQ-016 While locked and in IDLE with the owner's valid_i low, a timeout counter increments; it clears on any accept or on leaving IDLE.
REQ-017 When the timeout counter reaches LOCK_TIMEOUT, the lock clears and priority flips in the same cycle; arbitration resumes the next cycle.
REQ-018 The non-granted requester's accept_o is never high; both accept_o are never high together.
REQ-019 valid_i is sampled only in IDLE; data_i, last_i and valid_i changes outside IDLE are ignored, and the captured byte is immune to them.
REQ-020 Baud and bit counters are internal; the bit counter counts 0..7, and the baud counter counts 0..DIV-1 and wraps.

Reset
REQ-021 Reset values: state IDLE, txd_o=1, busy_o=0, grant_o=2'b00, both accept_o=0, counters 0, priority to dbg.
REQ-022 Reset asserted mid-frame forces txd_o high immediately and discards the frame and any lock; after release, no partial frame is resumed.

Structure
REQ-023 A shared package holds the state enumeration, requester index constants (REQ_DBG=0, REQ_APP=1) and the DIV computation function.
REQ-024 A single sub-module, uart_tx_serializer, holds the state machine, counters and txd_o register; arbitration, lock and timeout logic live in uart_tx_arbiter.

Verification
REQ-025 CLK_FREQ=8, BAUDRATE=2 (DIV=4); dbg sends 0xA5 with last=1 -> txd_o reads 0,1,0,1,0,0,1,0,1,1, each held 4 cycles, starting the cycle after accept; busy_o is high for 40 cycles.
REQ-026 Both requesters valid from reset with single-byte packets (dbg 0x11, app 0x22, each repeatedly) -> accepts alternate dbg, app, dbg, app, with 41-cycle spacing.
REQ-027 dbg sends a 3-byte packet 0x01,0x02,0x03 (last on 0x03) while app is continuously valid -> all three dbg bytes go first, then app; grant_o=2'b01 from the first accept until the 0x03 accept.
REQ-028 LOCK_TIMEOUT=16; dbg sends 0x01 (last=0) then drops valid while app is valid -> 16 IDLE cycles after the frame, the lock clears and app is accepted on the next cycle.
REQ-029 rst_ni is pulled low in DATA bit 3 -> txd_o=1 the same cycle; after release, grant_o=0, and the next accept starts a fresh start bit.
REQ-030 Requester data changes while busy_o=1 -> the transmitted frame matches the byte captured at accept.
